// File: rtl/mult_seq_arbiter.sv
// Shift-and-add multiplier shared by two requesters under round-robin arbitration.
// One WIDTH-bit adder is reused over WIDTH cycles to produce each 2*WIDTH-bit product.
module mult_seq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] res_data,
    output logic               res_tag,
    input  logic               res_ready,
    output logic               busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CW-1:0]      count_q;
    logic               tag_q;
    logic               last_served_q;
    logic               res_valid_q;
    logic [2*WIDTH-1:0] res_data_q;
    logic               res_tag_q;

    logic               grant0;
    logic               grant1;
    logic [WIDTH:0]     sum_d;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   mplier_d;

    // Requester 0 wins a tie unless it was the one served last.
    assign grant0 = req0_valid & (~req1_valid | last_served_q);
    assign grant1 = req1_valid & ~grant0;

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;

    // {acc, mplier} shifts right by one with the adder carry entering at the top.
    always_comb begin
        sum_d    = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_d    = sum_d[WIDTH:1];
        mplier_d = {sum_d[0], mplier_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            tag_q         <= 1'b0;
            last_served_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_tag_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        mcand_q       <= req0_a;
                        mplier_q      <= req0_b;
                        acc_q         <= '0;
                        count_q       <= '0;
                        tag_q         <= 1'b0;
                        last_served_q <= 1'b0;
                        state_q       <= RUN;
                    end else if (grant1) begin
                        mcand_q       <= req1_a;
                        mplier_q      <= req1_b;
                        acc_q         <= '0;
                        count_q       <= '0;
                        tag_q         <= 1'b1;
                        last_served_q <= 1'b1;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_q + CW'(1);
                    if (count_q == LAST_COUNT) begin
                        res_data_q  <= {acc_d, mplier_d};
                        res_tag_q   <= tag_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign busy      = (state_q != IDLE);

endmodule
